// File: rtl/checkbits_monitor_if.sv
// Bundle between firmware-status driver and checkbits_monitor: run controls in, sticky results out.
// Purely combinational wiring; no flow control on either side.
interface checkbits_monitor_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMER_W = 20
);
  logic               enable;
  logic               clear;
  logic [WIDTH-1:0]   checkbits_in;
  logic               alive;
  logic               done;
  logic               pass;
  logic               fail;
  logic               unknown;
  logic               timeout;
  logic               done_pulse;
  logic [WIDTH-1:0]   code_out;
  logic [2:0]         state_out;
  logic [TIMER_W-1:0] cycles_out;

  modport master (
    output enable, clear, checkbits_in,
    input  alive, done, pass, fail, unknown, timeout, done_pulse, code_out, state_out, cycles_out
  );

  modport slave (
    input  enable, clear, checkbits_in,
    output alive, done, pass, fail, unknown, timeout, done_pulse, code_out, state_out, cycles_out
  );
endinterface

// File: rtl/checkbits_monitor.sv
// Self-test monitor: resynchronises a firmware status word, accepts stable codes, tracks alive -> result.
// State/flags update SYNC_STAGES+STABLE_CYCLES edges after the input changes; no backpressure, input is sampled.
module checkbits_monitor #(
  parameter int unsigned      WIDTH          = 16,
  parameter logic [WIDTH-1:0] ALIVE_CODE     = WIDTH'(16'h0ffe),
  parameter logic [WIDTH-1:0] PASS_CODE      = WIDTH'(16'h00d5),
  parameter logic [WIDTH-1:0] FAIL_CODE      = WIDTH'(16'h7345),
  parameter int unsigned      SYNC_STAGES    = 2,
  parameter int unsigned      STABLE_CYCLES  = 4,
  parameter int unsigned      TIMEOUT_CYCLES = 500000,
  parameter int unsigned      TIMER_W        = 20
) (
  input logic                clock,
  input logic                resetb,
  checkbits_monitor_if.slave mon
);
  localparam int unsigned        CNT_W       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   STABLE_VAL  = CNT_W'(STABLE_CYCLES);
  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);
  localparam bit                 TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_WAIT_ALIVE = 3'd0,
    ST_RUNNING    = 3'd1,
    ST_PASS       = 3'd2,
    ST_FAIL       = 3'd3,
    ST_UNKNOWN    = 3'd4,
    ST_TIMEOUT    = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]   s;
  logic [WIDTH-1:0]   s_prev_q;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic               accept_q, accept_d;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   code_q, code_d;
  logic [TIMER_W-1:0] timer_q;
  logic               non_term, expire, enter_term, timer_inc;
  logic               alive_q, done_q, pass_q, fail_q, unknown_q, timeout_q, done_pulse_q;

  assign s = sync_q[SYNC_STAGES-1];

  // A change restarts the run at 1; accept fires only on the cycle the run first hits the target.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (s != s_prev_q) begin
      run_cnt_d = CNT_W'(1);
    end else if (run_cnt_q < STABLE_VAL) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
    accept_d = (run_cnt_d == STABLE_VAL) && ((s != s_prev_q) || (run_cnt_q != STABLE_VAL));
  end

  // s_prev_q doubles as the accepted value: it holds the sample that completed the run.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_q    <= '0;
      s_prev_q  <= '0;
      run_cnt_q <= '0;
      accept_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], mon.checkbits_in};
      s_prev_q <= s;
      if (mon.clear) begin
        run_cnt_q <= '0;
        accept_q  <= 1'b0;
      end else begin
        run_cnt_q <= run_cnt_d;
        accept_q  <= accept_d;
      end
    end
  end

  assign non_term = (state_q == ST_WAIT_ALIVE) || (state_q == ST_RUNNING);
  assign expire   = TIMEOUT_EN && (timer_q >= TIMEOUT_VAL);

  // An accept that moves the FSM takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (mon.enable) begin
      case (state_q)
        ST_WAIT_ALIVE: begin
          if (accept_q && (s_prev_q == ALIVE_CODE)) begin
            state_d = ST_RUNNING;
          end else if (expire) begin
            state_d = ST_TIMEOUT;
            code_d  = s;
          end
        end
        ST_RUNNING: begin
          if (accept_q && (s_prev_q != ALIVE_CODE)) begin
            code_d = s_prev_q;
            if (s_prev_q == PASS_CODE)      state_d = ST_PASS;
            else if (s_prev_q == FAIL_CODE) state_d = ST_FAIL;
            else                            state_d = ST_UNKNOWN;
          end else if (expire) begin
            state_d = ST_TIMEOUT;
            code_d  = s;
          end
        end
        default: ;
      endcase
    end
    enter_term = non_term && (state_d != ST_WAIT_ALIVE) && (state_d != ST_RUNNING);
    timer_inc  = mon.enable && non_term && !expire && (timer_q != '1);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_WAIT_ALIVE;
      code_q       <= '0;
      timer_q      <= '0;
      alive_q      <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      unknown_q    <= 1'b0;
      timeout_q    <= 1'b0;
      done_pulse_q <= 1'b0;
    end else if (mon.clear) begin
      state_q      <= ST_WAIT_ALIVE;
      code_q       <= '0;
      timer_q      <= '0;
      alive_q      <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      unknown_q    <= 1'b0;
      timeout_q    <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      done_pulse_q <= enter_term;
      if (timer_inc) timer_q <= timer_q + 1'b1;
      if ((state_q == ST_WAIT_ALIVE) && (state_d == ST_RUNNING)) alive_q <= 1'b1;
      if (enter_term) begin
        done_q    <= 1'b1;
        pass_q    <= pass_q    || (state_d == ST_PASS);
        fail_q    <= fail_q    || (state_d == ST_FAIL);
        unknown_q <= unknown_q || (state_d == ST_UNKNOWN);
        timeout_q <= timeout_q || (state_d == ST_TIMEOUT);
      end
    end
  end

  assign mon.alive      = alive_q;
  assign mon.done       = done_q;
  assign mon.pass       = pass_q;
  assign mon.fail       = fail_q;
  assign mon.unknown    = unknown_q;
  assign mon.timeout    = timeout_q;
  assign mon.done_pulse = done_pulse_q;
  assign mon.code_out   = code_q;
  assign mon.state_out  = state_q;
  assign mon.cycles_out = timer_q;
endmodule

// File: tb/tb_checkbits_monitor.sv
// Bench for checkbits_monitor: directed latency/timeout/clear/enable/reset steps, then random code
// sequences scored against a segment-level model of the alive -> result rules.
module tb_checkbits_monitor;
  localparam logic [15:0] ALIVE  = 16'h0ffe;
  localparam logic [15:0] PASS   = 16'h00d5;
  localparam logic [15:0] FAIL   = 16'h7345;
  localparam int          SYNC   = 2;
  localparam int          STABLE = 4;

  logic clock  = 1'b0;
  logic resetb = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  checkbits_monitor_if #(.WIDTH(16), .TIMER_W(20)) ifa ();
  checkbits_monitor_if #(.WIDTH(16), .TIMER_W(8))  ift ();

  checkbits_monitor dut_a (.clock(clock), .resetb(resetb), .mon(ifa));
  checkbits_monitor #(.TIMEOUT_CYCLES(100), .TIMER_W(8)) dut_t (.clock(clock), .resetb(resetb), .mon(ift));

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {alive, done, pass, fail, unknown, timeout, done_pulse}
  function automatic logic [31:0] fa();
    return {25'd0, ifa.alive, ifa.done, ifa.pass, ifa.fail, ifa.unknown, ifa.timeout, ifa.done_pulse};
  endfunction

  function automatic logic [31:0] ft();
    return {25'd0, ift.alive, ift.done, ift.pass, ift.fail, ift.unknown, ift.timeout, ift.done_pulse};
  endfunction

  logic [15:0] vals[$];
  int          lens[$];
  logic [15:0] last_in, prev, m_code;
  int          nseg, off, m_state, m_term_edge, pulses;
  logic        m_alive;
  logic [31:0] exp_flags, exp_cycles;

  initial begin
    ifa.enable = 1'b0; ifa.clear = 1'b0; ifa.checkbits_in = '0;
    ift.enable = 1'b0; ift.clear = 1'b0; ift.checkbits_in = '0;
    #1 resetb = 1'b0;
    #1;
    check("rst_a_flags", fa(), 0);
    check("rst_a_state", 32'(ifa.state_out), 0);
    check("rst_a_code", 32'(ifa.code_out), 0);
    check("rst_a_cycles", 32'(ifa.cycles_out), 0);
    check("rst_t_flags", ft(), 0);
    repeat (3) @(posedge clock);
    #1 resetb = 1'b1;

    // Timeout with no alive: timer stops at 100 as state becomes TIMEOUT.
    ift.enable = 1'b1; ift.clear = 1'b1; ift.checkbits_in = 16'h0000;
    step(1); ift.clear = 1'b0;
    check("to_cycles0", 32'(ift.cycles_out), 0);
    step(100);
    check("to_pre_state", 32'(ift.state_out), 0);
    check("to_pre_cycles", 32'(ift.cycles_out), 100);
    step(1);
    check("to_state", 32'(ift.state_out), 5);
    check("to_flags", ft(), 'b0100011);
    check("to_code", 32'(ift.code_out), 0);
    step(4);
    check("to_frozen", 32'(ift.cycles_out), 100);
    check("to_pulse_gone", ft(), 'b0100010);

    // Pass accept lands on the same cycle the timeout expires.
    ift.clear = 1'b1; ift.checkbits_in = ALIVE;
    step(1); ift.clear = 1'b0;
    step(94); ift.checkbits_in = PASS;
    step(6);
    check("co_pre_state", 32'(ift.state_out), 1);
    check("co_pre_cycles", 32'(ift.cycles_out), 100);
    step(1);
    check("co_state", 32'(ift.state_out), 2);
    check("co_flags", ft(), 'b1110001);
    check("co_code", 32'(ift.code_out), 32'(PASS));

    // Default flow: alive then pass, six edges after each first sampling edge.
    ifa.enable = 1'b1; ifa.clear = 1'b1; ifa.checkbits_in = ALIVE;
    step(1); ifa.clear = 1'b0;
    step(5);
    check("df_alive_early", fa(), 0);
    step(1);
    check("df_alive", fa(), 'b1000000);
    check("df_run_state", 32'(ifa.state_out), 1);
    step(3); ifa.checkbits_in = PASS;
    step(6);
    check("df_pass_early", 32'(ifa.state_out), 1);
    step(1);
    check("df_pass_state", 32'(ifa.state_out), 2);
    check("df_pass_flags", fa(), 'b1110001);
    check("df_code", 32'(ifa.code_out), 32'(PASS));
    check("df_cycles", 32'(ifa.cycles_out), 16);
    step(1);
    check("df_pulse_once", fa(), 'b1110000);
    check("df_cycles_frozen", 32'(ifa.cycles_out), 16);

    // Clear restarts everything; alive is recognised again.
    ifa.clear = 1'b1;
    step(1); ifa.clear = 1'b0;
    check("cl_flags", fa(), 0);
    check("cl_state", 32'(ifa.state_out), 0);
    check("cl_cycles", 32'(ifa.cycles_out), 0);
    check("cl_code", 32'(ifa.code_out), 0);
    ifa.checkbits_in = ALIVE;
    step(3);
    check("cl_wait", 32'(ifa.state_out), 0);
    step(4);
    check("cl_realive", fa(), 'b1000000);

    // Three-cycle glitch of PASS is rejected; four cycles is accepted.
    ifa.checkbits_in = PASS;
    step(3); ifa.checkbits_in = ALIVE;
    step(12);
    check("gl_reject_state", 32'(ifa.state_out), 1);
    check("gl_reject_flags", fa(), 'b1000000);
    ifa.checkbits_in = PASS;
    step(4); ifa.checkbits_in = ALIVE;
    step(3);
    check("gl_accept_state", 32'(ifa.state_out), 2);
    check("gl_accept_flags", fa(), 'b1110001);

    // Fail and unknown results.
    ifa.clear = 1'b1; ifa.checkbits_in = ALIVE;
    step(1); ifa.clear = 1'b0;
    step(9); ifa.checkbits_in = FAIL;
    step(8);
    check("fl_state", 32'(ifa.state_out), 3);
    check("fl_flags", fa(), 'b1101000);
    check("fl_code", 32'(ifa.code_out), 32'(FAIL));
    ifa.clear = 1'b1; ifa.checkbits_in = ALIVE;
    step(1); ifa.clear = 1'b0;
    step(9); ifa.checkbits_in = 16'h1234;
    step(8);
    check("uk_state", 32'(ifa.state_out), 4);
    check("uk_flags", fa(), 'b1100100);
    check("uk_code", 32'(ifa.code_out), 32'h1234);

    // enable=0 drops an accept; a code held across re-enable is not re-accepted.
    ifa.clear = 1'b1; ifa.checkbits_in = ALIVE;
    step(1); ifa.clear = 1'b0;
    step(10);
    check("en_cycles_a", 32'(ifa.cycles_out), 10);
    ifa.enable = 1'b0; ifa.checkbits_in = PASS;
    step(12);
    check("en_off_state", 32'(ifa.state_out), 1);
    check("en_off_cycles", 32'(ifa.cycles_out), 10);
    ifa.enable = 1'b1;
    step(10);
    check("en_on_state", 32'(ifa.state_out), 1);
    check("en_on_cycles", 32'(ifa.cycles_out), 20);
    check("en_on_flags", fa(), 'b1000000);

    // Asynchronous reset mid-run clears outputs before the next clock edge.
    #2 resetb = 1'b0;
    #1;
    check("ar_a_flags", fa(), 0);
    check("ar_a_state", 32'(ifa.state_out), 0);
    check("ar_a_cycles", 32'(ifa.cycles_out), 0);
    check("ar_t_flags", ft(), 0);
    check("ar_t_code", 32'(ift.code_out), 0);
    @(posedge clock);
    #1 resetb = 1'b1;
    last_in = ifa.checkbits_in;

    // Random code sequences: each segment holds a value for a number of input samples.
    for (int t = 0; t < 30; t++) begin
      vals.delete(); lens.delete();
      nseg = $urandom_range(2, 7);
      prev = last_in;
      for (int i = 0; i < nseg; i++) begin
        logic [15:0] v;
        int          r;
        r = $urandom_range(0, 9);
        if (i == 0)     v = (r < 7) ? ALIVE : 16'($urandom);
        else if (r < 2) v = ALIVE;
        else if (r < 4) v = PASS;
        else if (r < 6) v = FAIL;
        else            v = 16'($urandom);
        while (v == prev) v = 16'($urandom);
        vals.push_back(v);
        lens.push_back((i == nseg - 1) ? 12 : int'($urandom_range(1, 8)));
        prev = v;
      end

      // Model: a segment counts iff held for STABLE samples; its effect lands SYNC+STABLE edges after it starts.
      m_state = 0; m_code = '0; m_alive = 1'b0; m_term_edge = -1; off = 0;
      foreach (vals[i]) begin
        if (lens[i] >= STABLE) begin
          if (m_state == 0 && vals[i] == ALIVE) begin
            m_state = 1; m_alive = 1'b1;
          end else if (m_state == 1 && vals[i] != ALIVE) begin
            m_state = (vals[i] == PASS) ? 2 : (vals[i] == FAIL) ? 3 : 4;
            m_code = vals[i];
            m_term_edge = off + SYNC + STABLE;
          end
        end
        off += lens[i];
      end
      exp_cycles = (m_term_edge >= 0) ? 32'(m_term_edge) : 32'(off - 1);
      exp_flags = {25'd0, m_alive, (m_state >= 2), (m_state == 2), (m_state == 3), (m_state == 4), 1'b0, 1'b0};

      ifa.clear = 1'b1;
      pulses = 0;
      foreach (vals[i]) begin
        ifa.checkbits_in = vals[i];
        for (int k = 0; k < lens[i]; k++) begin
          step(1);
          ifa.clear = 1'b0;
          pulses += int'(ifa.done_pulse);
        end
      end
      last_in = vals[vals.size() - 1];

      check($sformatf("rnd%0d_state", t), 32'(ifa.state_out), 32'(m_state));
      check($sformatf("rnd%0d_flags", t), fa(), exp_flags);
      check($sformatf("rnd%0d_code", t), 32'(ifa.code_out), 32'(m_code));
      check($sformatf("rnd%0d_cycles", t), 32'(ifa.cycles_out), exp_cycles);
      check($sformatf("rnd%0d_pulses", t), 32'(pulses), (m_state >= 2) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/checkbits_monitor.md
Name: checkbits_monitor

Overview:
- Synthesizable self-test result monitor for Microwatt bring-up and regression.
- Watches a parametrised-width status word driven by firmware onto GPIO and resynchronises it.
- Accepts a code only after it has been stable for a programmable number of cycles.
- Tracks the alive → pass/fail/unknown sequence with a programmable timeout, and reports sticky result flags, the captured code and elapsed cycles for on-chip logic or a logic analyser.

Parameters:
WIDTH, 16, width of the status word
ALIVE_CODE, 16'h0ffe, code firmware writes once running
PASS_CODE, 16'h00d5, success code
FAIL_CODE, 16'h7345, failure code
SYNC_STAGES, 2, synchroniser depth on the status word (≥2)
STABLE_CYCLES, 4, consecutive equal samples required before a code is accepted (≥1)
TIMEOUT_CYCLES, 500000, cycles allowed before a terminal state is reached; 0 disables timeout
TIMER_W, 20, elapsed-cycle counter width; must hold TIMEOUT_CYCLES

Ports:
clock  input  1  system clock
resetb  input  1  asynchronous active-low reset
enable  input  1  FSM transitions and timer advance only when 1
clear  input  1  synchronous restart to WAIT_ALIVE; clears flags and counters
checkbits_in  input  WIDTH  asynchronous status word from GPIO
alive  output  1  sticky; ALIVE_CODE accepted
done  output  1  sticky; any terminal state reached
pass  output  1  sticky; PASS state
fail  output  1  sticky; FAIL state
unknown  output  1  sticky; UNKNOWN state
timeout  output  1  sticky; TIMEOUT state
done_pulse  output  1  one-cycle pulse on entry to any terminal state
code_out  output  WIDTH  code that caused the terminal transition
state_out  output  3  0 WAIT_ALIVE, 1 RUNNING, 2 PASS, 3 FAIL, 4 UNKNOWN, 5 TIMEOUT
cycles_out  output  TIMER_W  elapsed enabled cycles

Behaviour:
- Reset (resetb low, async): every output is 0.
  - state = WAIT_ALIVE, synchroniser flops = 0, stability counter = 0, timer = 0.
- Synchroniser: SYNC_STAGES flops; sampled value s is the last stage.
- Stability filter (runs regardless of enable):
  - When s != previous s, the run counter loads 1; otherwise it increments, saturating at STABLE_CYCLES.
  - accept strobes for exactly one cycle, when the run counter first reaches STABLE_CYCLES; the accepted value is s.
- Latency:
  - checkbits_in changes, then is held; the first clock edge sampling the new value is edge 0.
  - accept is asserted after edge SYNC_STAGES+STABLE_CYCLES-1.
  - State and flags update at edge SYNC_STAGES+STABLE_CYCLES (all outputs registered).
  - A glitch shorter than STABLE_CYCLES synchronised cycles is never accepted.
- FSM (transitions only when enable=1):
  - WAIT_ALIVE: accept with ALIVE_CODE → RUNNING and set alive. All other accepted codes are ignored, including 0 from reset.
  - RUNNING: accept with a value other than ALIVE_CODE → terminal state; code_out ← value.
    - PASS_CODE → PASS.
    - FAIL_CODE → FAIL.
    - Otherwise → UNKNOWN.
  - Terminal states (PASS, FAIL, UNKNOWN, TIMEOUT) hold until clear or reset; further accepts are ignored.
- Timer:
  - Increments when enable=1 and state ∈ {WAIT_ALIVE, RUNNING}; frozen otherwise. cycles_out = timer.
  - When TIMEOUT_CYCLES ≠ 0 and the timer reaches TIMEOUT_CYCLES in a non-terminal state: next edge → TIMEOUT, set timeout, code_out ← s.
- Accept in the same cycle as timeout expiry: accept wins.
- done_pulse asserts for exactly one cycle on each terminal entry; done is set alongside it.
- clear:
  - Synchronous and overrides enable and accept.
  - Next state WAIT_ALIVE; flags, code_out, timer and stability counter cleared; synchroniser retains its data.
  - Clear applied mid-run behaves identically to reset except for synchroniser contents.
- enable=0 in RUNNING:
  - Accepts are dropped, not queued.
  - A code still stable when enable returns is not re-accepted, since the filter is saturated.
- Async reset asserted mid-operation immediately returns all outputs to 0; release is synchronous to clock in the integration.

Test Plan:
- Defaults. Drive 0x0ffe, hold 10 cycles, then 0x00d5 → alive=1, then pass=1, done=1, code_out=0x00d5, state_out=2; done_pulse high exactly 1 cycle; each transition occurs 6 edges after the first sampling edge.
- Alive, then 0x7345 → fail=1, state_out=3. Separate run: alive, then 0x1234 → unknown=1, code_out=0x1234, state_out=4.
- TIMEOUT_CYCLES=100, never drive alive → timeout=1, state_out=5 at cycles_out=100; the timer then freezes.
- Alive, then pulse 0x00d5 for 3 cycles, then back to 0x0ffe → stays RUNNING, pass=0. Hold 0x00d5 for 4 cycles → pass=1.
- After pass, assert clear for 1 cycle → all flags 0, state_out=0, cycles_out=0. Re-drive 0x0ffe → alive=1 again.
- Accept and timeout coincident (TIMEOUT_CYCLES tuned): pass wins. Assert resetb low mid-RUNNING → all outputs 0 asynchronously, before the next clock edge.
